// File: rtl/obi_arb_2x1.sv
// Two-initiator to one-target OBI arbiter with a single outstanding transaction.
// Supports fixed-priority or round-robin arbitration, selected by ss_ctrl_arb[1].
module obi_arb_2x1 #(
  parameter int OBI_AW    = 32,
  parameter int OBI_DW    = 32,
  parameter int SS_CTRL_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SS_CTRL_W-1:0] ss_ctrl_arb,

  input  logic                 m0_req,
  input  logic [OBI_AW-1:0]    m0_addr,
  input  logic                 m0_we,
  input  logic [OBI_DW/8-1:0]  m0_be,
  input  logic [OBI_DW-1:0]    m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [OBI_DW-1:0]    m0_rdata,
  output logic                 m0_err,

  input  logic                 m1_req,
  input  logic [OBI_AW-1:0]    m1_addr,
  input  logic                 m1_we,
  input  logic [OBI_DW/8-1:0]  m1_be,
  input  logic [OBI_DW-1:0]    m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [OBI_DW-1:0]    m1_rdata,
  output logic                 m1_err,

  output logic                 tgt_req,
  output logic [OBI_AW-1:0]    tgt_addr,
  output logic                 tgt_we,
  output logic [OBI_DW/8-1:0]  tgt_be,
  output logic [OBI_DW-1:0]    tgt_wdata,
  input  logic                 tgt_gnt,
  input  logic                 tgt_rvalid,
  input  logic [OBI_DW-1:0]    tgt_rdata,
  input  logic                 tgt_err,

  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   prio_q, prio_d;
  logic   winner;
  logic   arb_en, fixed_mode;

  assign arb_en     = ss_ctrl_arb[0];
  assign fixed_mode = ss_ctrl_arb[1];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  // A lone requester wins outright; contention resolves by mode.
  always_comb begin
    if (m0_req && m1_req) begin
      winner = fixed_mode ? 1'b0 : prio_q;
    end else begin
      winner = m1_req;
    end
  end

  // NOTE: every variable gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (arb_en && (m0_req || m1_req)) begin
          state_d = ADDR;
          owner_d = winner;
        end
      end
      ADDR: begin
        if (tgt_gnt) state_d = RESP;
      end
      RESP: begin
        if (tgt_rvalid) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so an abandoned transfer never completes.
  logic in_addr, in_resp, gnt_fire, rsp_fire;

  assign in_addr  = !reset && (state_q == ADDR);
  assign in_resp  = !reset && (state_q == RESP);
  assign gnt_fire = in_addr && tgt_gnt;
  assign rsp_fire = in_resp && tgt_rvalid;

  assign tgt_req   = in_addr;
  assign tgt_addr  = in_addr ? (owner_q ? m1_addr  : m0_addr)  : '0;
  assign tgt_we    = in_addr ? (owner_q ? m1_we    : m0_we)    : 1'b0;
  assign tgt_be    = in_addr ? (owner_q ? m1_be    : m0_be)    : '0;
  assign tgt_wdata = in_addr ? (owner_q ? m1_wdata : m0_wdata) : '0;

  assign m0_gnt    = gnt_fire && !owner_q;
  assign m1_gnt    = gnt_fire &&  owner_q;

  assign m0_rvalid = rsp_fire && !owner_q;
  assign m1_rvalid = rsp_fire &&  owner_q;
  assign m0_rdata  = m0_rvalid ? tgt_rdata : '0;
  assign m1_rdata  = m1_rvalid ? tgt_rdata : '0;
  assign m0_err    = m0_rvalid && tgt_err;
  assign m1_err    = m1_rvalid && tgt_err;

  assign busy = !reset && (state_q != IDLE);

endmodule

// File: tb/tb_obi_arb_2x1.sv
// Self-checking bench for obi_arb_2x1: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_obi_arb_2x1;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic [1:0]    ss_ctrl_arb;
  logic          m0_req, m1_req, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [3:0]    m0_be, m1_be;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          tgt_req, tgt_we, tgt_gnt, tgt_rvalid, tgt_err;
  logic [AW-1:0] tgt_addr;
  logic [3:0]    tgt_be;
  logic [DW-1:0] tgt_wdata, tgt_rdata;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  obi_arb_2x1 #(.OBI_AW(AW), .OBI_DW(DW), .SS_CTRL_W(2)) dut (
    .clk(clk), .reset(reset), .ss_ctrl_arb(ss_ctrl_arb),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .tgt_req(tgt_req), .tgt_addr(tgt_addr), .tgt_we(tgt_we), .tgt_be(tgt_be),
    .tgt_wdata(tgt_wdata), .tgt_gnt(tgt_gnt), .tgt_rvalid(tgt_rvalid),
    .tgt_rdata(tgt_rdata), .tgt_err(tgt_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [140:0] all_outs();
    return {tgt_req, tgt_addr, tgt_we, tgt_be, tgt_wdata,
            m0_gnt, m0_rvalid, m0_rdata, m0_err,
            m1_gnt, m1_rvalid, m1_rdata, m1_err, busy};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ss_ctrl_arb = 2'b00;
    m0_req = 0; m0_addr = '0; m0_we = 0; m0_be = '0; m0_wdata = '0;
    m1_req = 0; m1_addr = '0; m1_we = 0; m1_be = '0; m1_wdata = '0;
    tgt_gnt = 0; tgt_rvalid = 0; tgt_rdata = '0; tgt_err = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    next_cycle();
    next_cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    ss_ctrl_arb = 2'b01;
    m0_req = 1; m1_req = 1; m0_addr = 32'h1111_0000; m1_addr = 32'h2222_0000;
    tgt_gnt = 1; tgt_rvalid = 1; tgt_rdata = $urandom; tgt_err = 1;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin
        reset = 0;
        ss_ctrl_arb = 2'b00;
      end
      @(negedge clk);
      n_checks++;
      if (all_outs() !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, all_outs());
      end
      next_cycle();
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_v;
    do_reset();
    ss_ctrl_arb = 2'b01;
    m0_req = 1; m0_addr = 32'h0103_0104; m0_we = 0; m0_be = 4'hF;
    tgt_gnt = 1; tgt_rvalid = 1; tgt_rdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) m0_req = 0;
      exp_v = {c == 1, c == 1, c == 2, c == 1 || c == 2};
      @(negedge clk);
      n_checks++;
      if ({tgt_req, m0_gnt, m0_rvalid, busy} !== exp_v) begin
        n_errors++;
        $display("FAIL single_ctrl cycle %0d: req/gnt/rvalid/busy got %b expected %b",
                 c, {tgt_req, m0_gnt, m0_rvalid, busy}, exp_v);
      end
      n_checks++;
      if ({m1_gnt, m1_rvalid, m1_err, m1_rdata} !== '0) begin
        n_errors++;
        $display("FAIL single_m1_quiet cycle %0d: got %h expected 0",
                 c, {m1_gnt, m1_rvalid, m1_err, m1_rdata});
      end
      if (c == 1) begin
        n_checks++;
        if (tgt_addr !== 32'h0103_0104) begin
          n_errors++;
          $display("FAIL single_addr: got %h expected 01030104", tgt_addr);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (m0_rdata !== 32'hDEAD_BEEF) begin
          n_errors++;
          $display("FAIL single_rdata: got %h expected deadbeef", m0_rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic run_contention(input logic fixed_mode, input string tag);
    int order[$];
    int m1_grants;
    do_reset();
    ss_ctrl_arb = {fixed_mode, 1'b1};
    m0_req = 1; m1_req = 1;
    m0_addr = {16'hA000, 16'($urandom)};
    m1_addr = {16'hB000, 16'($urandom)};
    tgt_gnt = 1; tgt_rvalid = 1; tgt_rdata = $urandom;
    m1_grants = 0;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      @(negedge clk);
      if (m1_gnt) m1_grants++;
      if (m0_gnt || m1_gnt) begin
        order.push_back(m1_gnt ? 1 : 0);
        n_checks++;
        if (tgt_addr !== (m1_gnt ? m1_addr : m0_addr) || (m0_gnt && m1_gnt)) begin
          n_errors++;
          $display("FAIL %s_addr grant %0d: tgt_addr %h gnt %b%b", tag, order.size(),
                   tgt_addr, m0_gnt, m1_gnt);
        end
      end
      next_cycle();
    end
    n_checks++;
    if (order.size() != 4) begin
      n_errors++;
      $display("FAIL %s_timeout: got %0d grants expected 4", tag, order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      n_checks++;
      if (order[i] != (fixed_mode ? 0 : i % 2)) begin
        n_errors++;
        $display("FAIL %s_order grant %0d: got m%0d expected m%0d", tag, i, order[i],
                 fixed_mode ? 0 : i % 2);
      end
    end
    if (fixed_mode) begin
      n_checks++;
      if (m1_grants != 0) begin
        n_errors++;
        $display("FAIL %s_m1_gnt: got %0d grants expected 0", tag, m1_grants);
      end
    end
  endtask

  task automatic test_round_robin();
    run_contention(1'b0, "round_robin");
  endtask

  task automatic test_fixed_priority();
    run_contention(1'b1, "fixed");
  endtask

  task automatic test_wait_err();
    logic [3:0]  exp_v;
    logic [68:0] exp_f;
    int busy_cycles;
    do_reset();
    ss_ctrl_arb = 2'b01;
    m0_addr = 32'h4000_0A0C; m0_we = 1; m0_be = 4'hA; m0_wdata = 32'h1234_5678;
    tgt_rdata = 32'h0BAD_F00D;
    busy_cycles = 0;
    for (int c = 0; c < 9; c++) begin
      m0_req     = (c <= 4);
      tgt_gnt    = (c == 4);
      tgt_rvalid = (c == 2) || (c == 7);
      tgt_err    = (c == 2) || (c == 7);
      exp_v = {c >= 1 && c <= 4, c == 4, c == 7, c == 7};
      exp_f = (c >= 1 && c <= 4) ? {32'h4000_0A0C, 1'b1, 4'hA, 32'h1234_5678} : '0;
      @(negedge clk);
      if (busy) busy_cycles++;
      n_checks++;
      if ({tgt_req, m0_gnt, m0_rvalid, m0_err} !== exp_v) begin
        n_errors++;
        $display("FAIL wait_ctrl cycle %0d: req/gnt/rvalid/err got %b expected %b",
                 c, {tgt_req, m0_gnt, m0_rvalid, m0_err}, exp_v);
      end
      n_checks++;
      if ({tgt_addr, tgt_we, tgt_be, tgt_wdata} !== exp_f) begin
        n_errors++;
        $display("FAIL wait_fields cycle %0d: got %h expected %h",
                 c, {tgt_addr, tgt_we, tgt_be, tgt_wdata}, exp_f);
      end
      next_cycle();
    end
    n_checks++;
    if (busy_cycles != 7) begin
      n_errors++;
      $display("FAIL wait_busy: got %0d busy cycles expected 7", busy_cycles);
    end
  endtask

  task automatic test_enable_drop();
    logic [5:0] exp_v;
    do_reset();
    m0_req = 1; m1_req = 1;
    m0_addr = 32'hA0A0_0000; m1_addr = 32'hB1B1_0000;
    tgt_gnt = 1; tgt_rdata = $urandom;
    for (int c = 0; c < 8; c++) begin
      ss_ctrl_arb = {1'b0, (c < 2) || (c >= 6)};
      tgt_rvalid  = (c == 3);
      exp_v = {c == 1 || c == 7, c == 1, c == 7, c == 3, 1'b0,
               (c >= 1 && c <= 3) || c == 7};
      @(negedge clk);
      n_checks++;
      if ({tgt_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy} !== exp_v) begin
        n_errors++;
        $display("FAIL enable_drop cycle %0d: req/g0/g1/rv0/rv1/busy got %b expected %b",
                 c, {tgt_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy}, exp_v);
      end
      if (c == 7) begin
        n_checks++;
        if (tgt_addr !== 32'hB1B1_0000) begin
          n_errors++;
          $display("FAIL enable_resume_addr: got %h expected b1b10000", tgt_addr);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp_v;
    do_reset();
    m0_req = 1; m1_req = 1;
    m0_addr = 32'hC000_0010; m1_addr = 32'hD000_0020;
    tgt_gnt = 1; tgt_rdata = $urandom;
    for (int c = 0; c < 9; c++) begin
      reset       = (c == 5);
      ss_ctrl_arb = {1'b0, c != 6};
      tgt_rvalid  = (c == 2) || (c == 5) || (c == 6);
      exp_v = {c == 1 || c == 4 || c == 8, c == 1 || c == 8, c == 4, c == 2, 1'b0,
               c == 1 || c == 2 || c == 4 || c == 8};
      @(negedge clk);
      n_checks++;
      if ({tgt_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy} !== exp_v) begin
        n_errors++;
        $display("FAIL reset_mid cycle %0d: req/g0/g1/rv0/rv1/busy got %b expected %b",
                 c, {tgt_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy}, exp_v);
      end
      next_cycle();
    end
    reset = 0;
  endtask

  // Reference model tracks one in-flight transaction record and a tie-break preference.
  task automatic test_random();
    bit         in_flight;
    bit         granted;
    int         owner;
    int         pref;
    logic [140:0] exp_o;
    logic       e_req, e_we, e_g0, e_g1, e_r0, e_r1, e_e0, e_e1, e_busy;
    logic [31:0] e_addr, e_wdata, e_d0, e_d1;
    logic [3:0] e_be;
    do_reset();
    in_flight = 0; granted = 0; owner = 0; pref = 0;
    ss_ctrl_arb = 2'b01;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 15) == 0) ss_ctrl_arb[0] = ~ss_ctrl_arb[0];
      if ($urandom_range(0, 15) == 0) ss_ctrl_arb[1] = ~ss_ctrl_arb[1];
      m0_req = ($urandom_range(0, 9) < 7); m1_req = ($urandom_range(0, 9) < 7);
      m0_addr = $urandom; m1_addr = $urandom; m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_be = 4'($urandom); m1_be = 4'($urandom);
      m0_wdata = $urandom; m1_wdata = $urandom;
      tgt_gnt = 1'($urandom); tgt_rvalid = 1'($urandom);
      tgt_rdata = $urandom; tgt_err = 1'($urandom);

      {e_req, e_we, e_g0, e_g1, e_r0, e_r1, e_e0, e_e1, e_busy} = '0;
      {e_addr, e_wdata, e_d0, e_d1, e_be} = '0;
      if (!reset && in_flight) begin
        e_busy = 1;
        if (!granted) begin
          e_req   = 1;
          e_addr  = (owner == 1) ? m1_addr  : m0_addr;
          e_we    = (owner == 1) ? m1_we    : m0_we;
          e_be    = (owner == 1) ? m1_be    : m0_be;
          e_wdata = (owner == 1) ? m1_wdata : m0_wdata;
          if (owner == 1) e_g1 = tgt_gnt; else e_g0 = tgt_gnt;
        end else if (tgt_rvalid) begin
          if (owner == 1) begin
            e_r1 = 1; e_d1 = tgt_rdata; e_e1 = tgt_err;
          end else begin
            e_r0 = 1; e_d0 = tgt_rdata; e_e0 = tgt_err;
          end
        end
      end
      exp_o = {e_req, e_addr, e_we, e_be, e_wdata, e_g0, e_r0, e_d0, e_e0,
               e_g1, e_r1, e_d1, e_e1, e_busy};

      @(negedge clk);
      n_checks++;
      if (all_outs() !== exp_o) begin
        n_errors++;
        $display("FAIL random cycle %0d: got %h expected %h", c, all_outs(), exp_o);
      end

      if (reset) begin
        in_flight = 0; pref = 0;
      end else if (!in_flight) begin
        if (ss_ctrl_arb[0] && (m0_req || m1_req)) begin
          if (m0_req && m1_req) owner = ss_ctrl_arb[1] ? 0 : pref;
          else                  owner = m1_req ? 1 : 0;
          in_flight = 1;
          granted   = 0;
        end
      end else if (!granted) begin
        if (tgt_gnt) granted = 1;
      end else if (tgt_rvalid) begin
        in_flight = 0;
        pref      = 1 - owner;
      end
      next_cycle();
    end
    reset = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_wait_err();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
